// File: rtl/batch_reverse_buffer.sv
// Ping-pong time-reversal buffer: fills one bank while the other
// is replayed newest-to-oldest, with first/last batch markers.
module batch_reverse_buffer #(
  parameter  int DEPTH  = 64,
  parameter  int f_exp  = 8,
  parameter  int f_mant = 23,
  localparam int W      = 2 * (1 + f_exp + f_mant)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         flush,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0] mem_q [2*DEPTH];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_active_q, rd_active_d;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_last_q, s1_last_d;
  logic [W-1:0]  s1_data_q, s1_data_d;

  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;

  logic          wr_en;
  logic          done;

  always_comb begin
    wr_en     = in_valid && !flush;
    done      = wr_en && (wr_cnt_q == LAST);
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (flush) begin
      wr_cnt_d = '0;
    end else if (in_valid) begin
      if (done) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // A completion reloads the reader even on the edge reading word 0.
  always_comb begin
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_active_d = rd_active_q;
    if (done) begin
      rd_bank_d   = wr_bank_q;
      rd_cnt_d    = LAST;
      rd_active_d = 1'b1;
    end else if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q - 1'b1;
      if (rd_cnt_q == '0) rd_active_d = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d = rd_active_q;
    s1_first_d = rd_active_q && (rd_cnt_q == LAST);
    s1_last_d  = rd_active_q && (rd_cnt_q == '0);
    s1_data_d  = s1_data_q;
    if (rd_active_q) s1_data_d = mem_q[{rd_bank_q, rd_cnt_q}];
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    out_first_d = s1_first_q;
    out_last_d  = s1_last_q;
    out_d       = s1_valid_q ? s1_data_q : out_q;
  end

  // Bank storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_cnt_q}] <= in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_active_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_active_q <= rd_active_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_data_q   <= s1_data_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_batch_reverse_buffer.sv
// Directed bench for batch_reverse_buffer at DEPTH=4:
// captured output stream is compared against hand-built batches.
module tb_batch_reverse_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 64;

  typedef struct {
    int          e;
    logic [63:0] d;
    logic        f;
    logic        l;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_first;
  logic         out_last;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_t = 0;
  int   t1, t2;
  rec_t got[$];
  rec_t exp_q[$];

  batch_reverse_buffer #(
    .DEPTH (DEPTH),
    .f_exp (8),
    .f_mant(23)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .flush    (flush),
    .out      (out),
    .out_valid(out_valid),
    .out_first(out_first),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (out_valid) got.push_back('{cyc, out, out_first, out_last});

  function automatic logic [63:0] mk(input int re);
    return {32'(re), 32'(re * 10)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int re);
    in       = mk(re);
    in_valid = 1'b1;
    flush    = 1'b0;
    last_t   = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic flush_for(input int n, input logic v);
    flush    = 1'b1;
    in_valid = v;
    in       = mk(99);
    repeat (n) @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic exp_batch(input int t, input int a, input int b,
                           input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{t + 2 + i, mk(v[i]), i == 0, i == 3});
  endtask

  task automatic check_case(input string tag);
    chk({tag, ".count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) begin
        chk($sformatf("%s[%0d].edge", tag, i), 64'(got[i].e),
            64'(exp_q[i].e));
        chk($sformatf("%s[%0d].data", tag, i), got[i].d, exp_q[i].d);
        chk($sformatf("%s[%0d].fl", tag, i), {62'd0, got[i].f, got[i].l},
            {62'd0, exp_q[i].f, exp_q[i].l});
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.out", out, 64'd0);
    chk("rst.flags", {61'd0, out_valid, out_first, out_last}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single batch
    for (int k = 1; k <= 4; k++) send(k);
    t1 = last_t;
    exp_batch(t1, 4, 3, 2, 1);
    idle(8);
    check_case("t1");

    // 2: back-to-back batches, gapless
    for (int k = 1; k <= 8; k++) begin
      send(k);
      if (k == 4) t1 = last_t;
    end
    t2 = last_t;
    exp_batch(t1, 4, 3, 2, 1);
    exp_batch(t2, 8, 7, 6, 5);
    idle(8);
    check_case("t2");

    // 3: gaps inside a batch
    send(1);
    send(2);
    idle(3);
    send(3);
    idle(1);
    send(4);
    exp_batch(last_t, 4, 3, 2, 1);
    idle(8);
    check_case("t3");

    // 4: flush discards partial batch, dropping in-flight sample
    send(1);
    send(2);
    flush_for(1, 1'b1);
    for (int k = 5; k <= 8; k++) send(k);
    exp_batch(last_t, 8, 7, 6, 5);
    idle(8);
    check_case("t4");

    // 5: async reset between words 3 and 2
    for (int k = 1; k <= 4; k++) send(k);
    t1 = last_t;
    exp_q.push_back('{t1 + 2, mk(4), 1'b1, 1'b0});
    exp_q.push_back('{t1 + 3, mk(3), 1'b0, 1'b0});
    while (cyc < t1 + 3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5.rst_flags", {61'd0, out_valid, out_first, out_last}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    check_case("t5a");
    for (int k = 9; k <= 12; k++) send(k);
    exp_batch(last_t, 12, 11, 10, 9);
    idle(8);
    check_case("t5b");

    // 6: flush held during readout; follow-up batch must start at count 0
    for (int k = 1; k <= 4; k++) send(k);
    exp_batch(last_t, 4, 3, 2, 1);
    flush_for(7, 1'b1);
    idle(4);
    check_case("t6a");
    for (int k = 21; k <= 24; k++) send(k);
    exp_batch(last_t, 24, 23, 22, 21);
    idle(8);
    check_case("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/batch_reverse_buffer.md
Name: batch_reverse_buffer

Overview:
- Ping-pong time-reversal buffer that sits directly downstream of the forward recursion stage.
- Takes one complex float sample per valid cycle, groups samples into batches of DEPTH and re-emits each completed batch in reverse order.
- Marks the first reversed word with a pulse that drives the `rst` input of the following backward recursion stage.
- Data words are opaque: no arithmetic is performed on them.

Parameters:
- DEPTH, 64, batch length in samples; power of two, DEPTH >= 2.
- f_exp, 8, float exponent width.
- f_mant, 23, float mantissa width.
- W, 2*(1+f_exp+f_mant), packed complex word width (real in the upper half, imaginary in the lower half); derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  W  complex_t sample from the recursion stage.
- in_valid  input  1  `in` is a valid sample this cycle.
- flush  input  1  synchronous; discards the partially written batch.
- out  output  W  reversed complex_t sample.
- out_valid  output  1  `out` is valid.
- out_first  output  1  high with the first word of each reversed batch.
- out_last  output  1  high with the last word of each reversed batch (the batch's oldest input).

Behaviour:
- Storage: two banks of DEPTH words each (bank 0, bank 1).
- State: wr_bank (1b), wr_cnt (log2 DEPTH bits), rd_bank (1b), rd_cnt (log2 DEPTH bits), rd_active.
- Reset (async, while rst=1), all state forced:
  - wr_bank=0, wr_cnt=0, rd_active=0, rd_cnt=0.
  - out=0, out_valid=0, out_first=0, out_last=0.
  - Bank contents are not reset.
- Reset mid-batch or mid-readout: both are abandoned with no further output; operation restarts cleanly at bank 0, count 0.
- Write, on each edge with in_valid=1 and flush=0:
  - bank[wr_bank][wr_cnt] <= in.
  - If wr_cnt = DEPTH-1 (batch completion): wr_cnt<=0, wr_bank toggles, read start is triggered. Otherwise wr_cnt increments.
- in_valid=0 leaves write state unchanged; gaps between samples are allowed at any point.
- flush=1: wr_cnt<=0, wr_bank unchanged, and the sample on `in` is dropped even if in_valid=1.
  - flush never affects an active readout.
  - flush together with a would-be completing sample: the flush wins and there is no completion.
- Read start, on a completion edge:
  - rd_bank <= the bank just filled, rd_cnt <= DEPTH-1, rd_active <= 1.
- While rd_active, one read per cycle: rd_cnt decrements. When rd_cnt = 0 is read, rd_active <= 0 unless a new completion occurs on that same edge, in which case the reload takes priority.
- Output timing:
  - Registered read path, fixed latency 2. If completion occurs on edge t, out_valid is high for edges t+2 through t+DEPTH+1 inclusive.
  - The words appear in the order bank[rd_bank][DEPTH-1] down to [0].
  - out_first is high on edge t+2 only; out_last is high on edge t+DEPTH+1 only.
  - The last-written word must be presented correctly even though it is written on edge t; bypass or pipeline as needed.
- Throughput: input rate is at most one sample per clock, so a batch completes at most once every DEPTH cycles. Readout therefore always finishes or reloads in time.
  - Back-to-back batches produce a gapless output stream: out_last of batch k is immediately followed, on the next edge, by out_first of batch k+1.
  - No overflow or underflow condition exists.
- When out_valid=0, out holds its last value; only out_valid is meaningful to consumers.

Test Plan:
1. DEPTH=4. Reset, then in = 1,2,3,4 (real field; imaginary = 10×) on consecutive cycles, completing on edge t. -> out_valid high on edges t+2..t+5; out = 4,3,2,1 (imaginary 40,30,20,10); out_first only with 4; out_last only with 1.
2. DEPTH=4, eight consecutive samples 1..8. -> gapless output 4,3,2,1,8,7,6,5; out_valid continuously high for 8 cycles; out_first with 4 and 8; out_last with 1 and 5.
3. DEPTH=4, samples 1,2 / idle 3 cycles / 3 / idle 1 cycle / 4. -> output 4,3,2,1 beginning 2 edges after the edge that captured 4; no output earlier.
4. DEPTH=4, samples 1,2, flush, then samples 5,6,7,8. -> output 8,7,6,5 only; samples 1 and 2 are never emitted.
5. DEPTH=4, samples 1..4, then assert rst asynchronously between out words 3 and 2. -> out_valid/out_first/out_last drop immediately with rst; after release, samples 9..12 yield 12,11,10,9 from bank 0.
6. DEPTH=4, samples 1..4, then flush held high with in_valid=1 during the readout. -> readout 4,3,2,1 completes unaffected; wr_cnt stays 0.
